jram_sequencer: RTL and testbench

//  Sequences the 256x8 jRAM (address register + set/enable strobes) for two requesters.

---
 rtl/jram_sequencer_pkg.sv | 29 ++
 rtl/jram_sequencer_if.sv | 40 ++++
 rtl/jram_sequencer_arb.sv | 38 +++
 rtl/jram_sequencer.sv | 168 ++++++++++++++++
 tb/tb_jram_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jram_sequencer_pkg.sv
// Shared types and constants for the jRAM access sequencer.
// Optional write verify is enabled with the JRAM_SEQUENCER_READBACK_EN macro.
package jram_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ASET   = 3'd1,
    AHOLD  = 3'd2,
    WSET   = 3'd3,
    RENA   = 3'd4,
    AHOLD2 = 3'd5,
    RVFY   = 3'd6,
    ACK    = 3'd7
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int SET_CYCLES_DEF = 2;
  localparam int ENA_CYCLES_DEF = 2;

  // Counter must be able to hold the longest strobe length.
  function automatic int cnt_width(input int set_cycles, input int ena_cycles);
    int m;
    m = (set_cycles > ena_cycles) ? set_cycles : ena_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/jram_sequencer_if.sv
// Request ports, status and jRAM strobe bus of the jRAM sequencer.
// slave = sequencer side, master = requesters plus the jRAM itself.
interface jram_sequencer_if;
  logic       r0_req;
  logic       r0_we;
  logic [7:0] r0_addr;
  logic [7:0] r0_wdata;
  logic       r0_ack;
  logic       r1_req;
  logic       r1_we;
  logic [7:0] r1_addr;
  logic [7:0] r1_wdata;
  logic       r1_ack;
  logic [7:0] rdata;
  logic       busy;
  logic       grant_id;
  logic       err;
  logic [7:0] ram_addr;
  logic       ram_sa;
  logic [7:0] ram_din;
  logic       ram_s;
  logic       ram_e;
  logic [7:0] ram_dout;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  ram_dout,
    output r0_ack, r1_ack, rdata, busy, grant_id, err,
    output ram_addr, ram_sa, ram_din, ram_s, ram_e
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output ram_dout,
    input  r0_ack, r1_ack, rdata, busy, grant_id, err,
    input  ram_addr, ram_sa, ram_din, ram_s, ram_e
  );
endinterface

// File: rtl/jram_sequencer_arb.sv
// Two-way round-robin arbiter; the last-grant register only moves when enabled.
// Reset leaves port 1 as last winner so port 0 gets the first tie.
module rr_arbiter2
  import jram_seq_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       en,
  input  logic [1:0] req,
  output logic       gnt_valid,
  output logic       gnt_id,
  output logic       last_id
);

  logic last_reg;

  always_comb begin
    gnt_valid = |req;
    gnt_id    = last_reg;
    case (req)
      2'b01:   gnt_id = PORT0;
      2'b10:   gnt_id = PORT1;
      2'b11:   gnt_id = ~last_reg;
      default: gnt_id = last_reg;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_reg <= PORT1;
    end else if (en && gnt_valid) begin
      last_reg <= gnt_id;
    end
  end

  assign last_id = last_reg;

endmodule

// File: rtl/jram_sequencer.sv
// Turns requests from two ports into jRAM address/set/enable strobe sequences.
// Define JRAM_SEQUENCER_READBACK_EN to verify every write with a readback.
module jram_sequencer
  import jram_seq_pkg::*;
#(
  parameter int SET_CYCLES = SET_CYCLES_DEF,
  parameter int ENA_CYCLES = ENA_CYCLES_DEF
) (
  input logic             CLK,
  input logic             RST_N,
  jram_sequencer_if.slave bus
);

  localparam int CW = cnt_width(SET_CYCLES, ENA_CYCLES);
  localparam logic [CW-1:0] SET_LAST = CW'(SET_CYCLES - 1);
  localparam logic [CW-1:0] ENA_LAST = CW'(ENA_CYCLES - 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next, cnt_last;
  logic            cnt_done;
  logic            we_reg;
  logic [7:0]      addr_reg, din_reg, rdata_reg;
  logic            arb_en, gnt_valid, gnt_id, last_id;
  logic            capture, rdata_load;
  logic            strobe_sa, strobe_s, strobe_e, ack_c;
  logic [1:0]      ack_vec;
`ifdef JRAM_SEQUENCER_READBACK_EN
  logic            verify;
  logic            err_reg;
`endif

  rr_arbiter2 u_arb (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .en        (arb_en),
    .req       ({bus.r1_req, bus.r0_req}),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .last_id   (last_id)
  );

  assign arb_en   = (state_reg == IDLE);
  assign cnt_last = (state_reg == WSET) ? SET_LAST : ENA_LAST;
  assign cnt_done = (cnt_reg == cnt_last);

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    capture    = 1'b0;
    rdata_load = 1'b0;
    strobe_sa  = 1'b0;
    strobe_s   = 1'b0;
    strobe_e   = 1'b0;
    ack_c      = 1'b0;
`ifdef JRAM_SEQUENCER_READBACK_EN
    verify     = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (gnt_valid) begin
          state_next = ASET;
          capture    = 1'b1;
        end
      end
      ASET: begin
        strobe_sa  = 1'b1;
        state_next = AHOLD;
      end
      AHOLD: begin
        state_next = we_reg ? WSET : RENA;
      end
      WSET: begin
        strobe_s = 1'b1;
        if (cnt_done) begin
`ifdef JRAM_SEQUENCER_READBACK_EN
          state_next = AHOLD2;
`else
          state_next = ACK;
`endif
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      RENA: begin
        strobe_e = 1'b1;
        if (cnt_done) begin
          state_next = ACK;
          rdata_load = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
`ifdef JRAM_SEQUENCER_READBACK_EN
      AHOLD2: begin
        state_next = RVFY;
      end
      RVFY: begin
        strobe_e = 1'b1;
        if (cnt_done) begin
          state_next = ACK;
          verify     = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
`endif
      ACK: begin
        ack_c      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The arbiter's last-grant register doubles as the owner of the access in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= 8'h00;
      din_reg   <= 8'h00;
      rdata_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (capture) begin
        we_reg   <= gnt_id ? bus.r1_we    : bus.r0_we;
        addr_reg <= gnt_id ? bus.r1_addr  : bus.r0_addr;
        din_reg  <= gnt_id ? bus.r1_wdata : bus.r0_wdata;
      end
      if (rdata_load) begin
        rdata_reg <= bus.ram_dout;
      end
    end
  end

`ifdef JRAM_SEQUENCER_READBACK_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_reg <= 1'b0;
    end else if (verify && (bus.ram_dout != din_reg)) begin
      err_reg <= 1'b1;
    end
  end
  assign bus.err = err_reg;
`else
  assign bus.err = 1'b0;
`endif

  for (genvar gi = 0; gi < 2; gi++) begin : g_ack
    assign ack_vec[gi] = ack_c && (last_id == 1'(gi));
  end

  assign bus.r0_ack   = ack_vec[0];
  assign bus.r1_ack   = ack_vec[1];
  assign bus.rdata    = rdata_reg;
  assign bus.busy     = (state_reg != IDLE);
  assign bus.grant_id = last_id;
  assign bus.ram_addr = addr_reg;
  assign bus.ram_din  = din_reg;
  assign bus.ram_sa   = strobe_sa;
  assign bus.ram_s    = strobe_s;
  assign bus.ram_e    = strobe_e;

endmodule

// File: tb/tb_jram_sequencer.sv
// Randomized self-checking bench for jram_sequencer with a simple jRAM device model.
// Build with JRAM_SEQUENCER_READBACK_EN defined to exercise the write-verify path.
module tb_jram_sequencer;

  localparam int SET_C  = 2;
  localparam int ENA_C  = 2;
  localparam int RD_LAT = 3 + ENA_C;
`ifdef JRAM_SEQUENCER_READBACK_EN
  localparam bit RB     = 1'b1;
  localparam int WR_LAT = 3 + SET_C + 1 + ENA_C;
  localparam int WR_E   = ENA_C;
`else
  localparam bit RB     = 1'b0;
  localparam int WR_LAT = 3 + SET_C;
  localparam int WR_E   = 0;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  jram_sequencer_if bus ();

  jram_sequencer #(.SET_CYCLES(SET_C), .ENA_CYCLES(ENA_C)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  // jRAM device: address latched on ram_sa, written on ram_s, read combinationally.
  logic [7:0] dev_mem [256];
  logic [7:0] dev_alat;
  bit         force_zero = 1'b0;
  always @(posedge CLK) begin
    if (bus.ram_sa) dev_alat <= bus.ram_addr;
    if (bus.ram_s)  dev_mem[dev_alat] <= bus.ram_din;
  end
  assign bus.ram_dout = force_zero ? 8'h00 : dev_mem[dev_alat];

  // Reference model: what the memory should hold and what the status outputs should show.
  logic [7:0] ref_mem [256];
  logic [7:0] ref_rdata;
  logic       err_exp;
  int         written[$];
  int         checks = 0;
  int         errors = 0;

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [7:0] a, input logic [7:0] d);
    if (port == 0) begin
      bus.r0_req = req; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
    end else begin
      bus.r1_req = req; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? bus.r0_ack : bus.r1_ack;
  endfunction

  // One full access; checks latency, strobe shape, captured values and results.
  task automatic do_access(input int port, input logic we, input logic [7:0] addr,
                           input logic [7:0] wdata, input bit mutate, input bit chk_rdata,
                           output logic [7:0] rd_obs);
    int n, sa_n, s_n, e_n, ovl, bad_a, bad_d, oth, nbusy, lat;
    bit got;
    n = 0; sa_n = 0; s_n = 0; e_n = 0; ovl = 0; bad_a = 0; bad_d = 0; oth = 0; nbusy = 0;
    got = 1'b0;
    lat = we ? WR_LAT : RD_LAT;
    @(negedge CLK);
    drive(port, 1'b1, we, addr, wdata);
    while (!got && n < 40) begin
      @(negedge CLK);
      n++;
      if (bus.ram_sa) sa_n++;
      if (bus.ram_s)  s_n++;
      if (bus.ram_e)  e_n++;
      if ((bus.ram_s && bus.ram_e) || (bus.ram_sa && (bus.ram_s || bus.ram_e))) ovl++;
      if ((bus.ram_sa || bus.ram_s || bus.ram_e) && bus.ram_addr !== addr) bad_a++;
      if (bus.ram_s && bus.ram_din !== wdata) bad_d++;
      if (ack_of(1 - port)) oth++;
      if (!bus.busy) nbusy++;
      if (ack_of(port)) got = 1'b1;
      if (mutate && n == 1) drive(port, 1'b1, we, ~addr, ~wdata);
    end
    drive(port, 1'b0, we, addr, wdata);
    rd_obs = bus.rdata;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ack_timeout port=%0d got=no required=ack within 40 cycles", port);
      return;
    end
    if (we) begin
      ref_mem[addr] = wdata;
      written.push_back(int'(addr));
      if (RB && ((force_zero ? 8'h00 : wdata) != wdata)) err_exp = 1'b1;
    end else begin
      ref_rdata = ref_mem[addr];
    end
    checks++;
    if (n !== lat) begin errors++; $display("FAIL latency port=%0d got=%0d required=%0d", port, n, lat); end
    checks++;
    if (sa_n !== 1) begin errors++; $display("FAIL sa_cycles got=%0d required=1", sa_n); end
    checks++;
    if (s_n !== (we ? SET_C : 0)) begin errors++; $display("FAIL s_cycles got=%0d required=%0d", s_n, we ? SET_C : 0); end
    checks++;
    if (e_n !== (we ? WR_E : ENA_C)) begin errors++; $display("FAIL e_cycles got=%0d required=%0d", e_n, we ? WR_E : ENA_C); end
    checks++;
    if (ovl !== 0) begin errors++; $display("FAIL strobe_overlap got=%0d required=0", ovl); end
    checks++;
    if (bad_a !== 0 || bad_d !== 0) begin errors++; $display("FAIL addr_din_stable bad_addr=%0d bad_din=%0d required=0", bad_a, bad_d); end
    checks++;
    if (oth !== 0 || nbusy !== 0) begin errors++; $display("FAIL other_ack_busy other=%0d notbusy=%0d required=0", oth, nbusy); end
    checks++;
    if (bus.grant_id !== 1'(port)) begin errors++; $display("FAIL grant_id got=%0d required=%0d", bus.grant_id, port); end
    if (chk_rdata) begin
      checks++;
      if (bus.rdata !== ref_rdata) begin errors++; $display("FAIL rdata addr=%02h got=%02h required=%02h", addr, bus.rdata, ref_rdata); end
    end
    @(negedge CLK);
    checks++;
    if (ack_of(port) !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL ack_pulse ack=%0b busy=%0b required=0 0", ack_of(port), bus.busy);
    end
    checks++;
    if (bus.err !== err_exp) begin errors++; $display("FAIL err got=%0b required=%0b", bus.err, err_exp); end
    $display("access port=%0d we=%0b addr=%02h wdata=%02h rdata=%02h lat=%0d", port, we, addr, wdata, rd_obs, n);
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({bus.r0_ack, bus.r1_ack, bus.busy, bus.err, bus.ram_sa, bus.ram_s, bus.ram_e} !== 7'b0 ||
        bus.rdata !== 8'h00 || bus.ram_addr !== 8'h00 || bus.ram_din !== 8'h00 || bus.grant_id !== 1'b1) begin
      errors++;
      $display("FAIL reset_state acks=%0b%0b busy=%0b err=%0b strobes=%0b%0b%0b rdata=%02h addr=%02h din=%02h gid=%0b required=all 0, gid=1",
               bus.r0_ack, bus.r1_ack, bus.busy, bus.err, bus.ram_sa, bus.ram_s, bus.ram_e,
               bus.rdata, bus.ram_addr, bus.ram_din, bus.grant_id);
    end
    RST_N = 1'b1;
    ref_rdata = 8'h00;
    err_exp   = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy=%0b required=0", bus.busy); end
    $display("reset released");
  endtask

  task automatic test_basic;
    logic [7:0] rd;
    do_access(0, 1'b1, 8'h3C, 8'hA5, 1'b0, 1'b1, rd);
    do_access(1, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b1, rd);
  endtask

  task automatic test_both;
    int order[$];
    int n, ovl, wide;
    logic p0, p1;
    logic [7:0] rd;
    do_access(1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b1, rd);
    @(negedge CLK);
    RST_N = 1'b0;
    drive(0, 1'b1, 1'b0, 8'h3C, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge CLK);
    RST_N = 1'b1;
    ref_rdata = 8'h00; err_exp = 1'b0;
    n = 0; ovl = 0; wide = 0; p0 = 1'b0; p1 = 1'b0;
    while (order.size() < 3 && n < 60) begin
      @(negedge CLK);
      n++;
      if ((bus.ram_s && bus.ram_e) || (bus.ram_sa && (bus.ram_s || bus.ram_e))) ovl++;
      if (bus.r0_ack && bus.r1_ack) ovl++;
      if ((bus.r0_ack && p0) || (bus.r1_ack && p1)) wide++;
      if (bus.r0_ack || bus.r1_ack) begin
        order.push_back(bus.r1_ack ? 1 : 0);
        ref_rdata = ref_mem[bus.r1_ack ? 8'h10 : 8'h3C];
        checks++;
        if (bus.rdata !== ref_rdata) begin errors++; $display("FAIL both_rdata got=%02h required=%02h", bus.rdata, ref_rdata); end
        $display("both ack port=%0d rdata=%02h cycle=%0d", bus.r1_ack ? 1 : 0, bus.rdata, n);
      end
      p0 = bus.r0_ack; p1 = bus.r1_ack;
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge CLK);
    checks++;
    if (order.size() != 3) begin
      errors++; $display("FAIL both_count got=%0d required=3", order.size());
    end else if (order[0] != 0 || order[1] != 1 || order[2] != 0) begin
      errors++; $display("FAIL both_order got=%0d%0d%0d required=010", order[0], order[1], order[2]);
    end
    checks++;
    if (ovl !== 0 || wide !== 0) begin errors++; $display("FAIL both_pulses overlap=%0d wide=%0d required=0", ovl, wide); end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [7:0] old_v, rd;
    old_v = ref_mem[8'h3C];
    n = 0;
    @(negedge CLK);
    drive(0, 1'b1, 1'b1, 8'h3C, 8'h77);
    while (!bus.ram_s && n < 20) begin @(negedge CLK); n++; end
    checks++;
    if (!bus.ram_s) begin errors++; $display("FAIL mid_reset_no_wset got=0 required=ram_s"); end
    #1 RST_N = 1'b0;
    #1;
    checks++;
    if ({bus.ram_sa, bus.ram_s, bus.ram_e, bus.busy, bus.r0_ack, bus.r1_ack} !== 6'b0) begin
      errors++; $display("FAIL mid_reset_outputs got=%0b%0b%0b%0b%0b%0b required=000000",
                         bus.ram_sa, bus.ram_s, bus.ram_e, bus.busy, bus.r0_ack, bus.r1_ack);
    end
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge CLK);
    RST_N = 1'b1;
    ref_rdata = 8'h00; err_exp = 1'b0;
    n = 0;
    repeat (6) begin @(negedge CLK); if (bus.r0_ack || bus.r1_ack || bus.busy) n++; end
    checks++;
    if (n !== 0) begin errors++; $display("FAIL mid_reset_ack got=%0d required=0", n); end
    do_access(1, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, rd);
    checks++;
    if ($isunknown(rd) || (rd !== old_v && rd !== 8'h77)) begin
      errors++; $display("FAIL mid_reset_data got=%02h required=%02h or 77", rd, old_v);
    end else begin
      ref_mem[8'h3C] = rd;
    end
    ref_rdata = rd;
  endtask

  task automatic test_capture;
    logic [7:0] rd;
    do_access(0, 1'b1, 8'h55, 8'hC3, 1'b1, 1'b1, rd);
    do_access(0, 1'b0, 8'h55, 8'h00, 1'b1, 1'b1, rd);
    do_access(1, 1'b0, 8'hAA, 8'h00, 1'b0, 1'b0, rd);
  endtask

  task automatic test_random;
    logic [7:0] rd, a, d;
    int p;
    logic we;
    for (int i = 0; i < 30; i++) begin
      p  = int'($urandom_range(0, 1));
      we = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if (we) a = 8'($urandom);
      else    a = 8'(written[$urandom_range(0, written.size() - 1)]);
      do_access(p, we, a, d, 1'($urandom_range(0, 1)), 1'b1, rd);
    end
  endtask

  task automatic test_readback;
    logic [7:0] rd;
    force_zero = 1'b1;
    do_access(0, 1'b1, 8'h20, 8'hFF, 1'b0, 1'b1, rd);
    force_zero = 1'b0;
    checks++;
    if (bus.err !== RB) begin errors++; $display("FAIL readback_err got=%0b required=%0b", bus.err, RB); end
    do_access(1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1, rd);
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    test_reset();
    test_basic();
    test_both();
    test_reset_mid();
    test_capture();
    test_random();
    test_readback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
